// File: rtl/rdid_capture.sv
// Passive SPI monitor: checks the RDID opcode on SPIMOSI, deserializes the 24-bit JEDEC ID from SPIMISO.
// Latency: id_valid 2 clk after the 32nd SPICLK rise is sampled; opcode_err 1 clk after the 8th rise.
// Backpressure: none; the monitor drives no bus and must keep up with SPICLK <= clk/4. Option: RDID_CAPTURE_TIMEOUT_EN.
module rdid_capture #(
    parameter logic [7:0]  OPCODE      = 8'h9F,
    parameter logic [23:0] EXP_ID      = 24'h202015,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        get_rdid,
    input  logic        SPICLK,
    input  logic        SPIMOSI,
    input  logic        SPIMISO,
    output logic        busy,
    output logic        id_valid,
    output logic [23:0] id_data,
    output logic        id_match,
    output logic        opcode_err,
    output logic        timeout
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("rdid_capture: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        DATA   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        spiclk_q;
    logic        rise;
    logic        start;
    logic [4:0]  bit_cnt;
    logic [7:0]  cmd_sr;
    logic [7:0]  cmd_nxt;
    logic [23:0] data_sr;
    logic        last_cmd_bit;
    logic        last_data_bit;
    logic        cmd_ok;
    logic        wd_expire;

    logic        busy_d;
    logic        id_valid_d;
    logic        id_match_d;
    logic        opcode_err_d;
    logic        timeout_d;

    assign rise          = SPICLK & ~spiclk_q;
    // busy stays high through the result pulse, so a strobe in that cycle is also ignored
    assign start         = (state == IDLE) && get_rdid && !busy;
    assign cmd_nxt       = {cmd_sr[6:0], SPIMOSI};
    assign cmd_ok        = (cmd_nxt == OPCODE);
    assign last_cmd_bit  = (state == CMD)  && rise && (bit_cnt == 5'd7);
    assign last_data_bit = (state == DATA) && rise && (bit_cnt == 5'd23);

`ifdef RDID_CAPTURE_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wdog;

    always_ff @(posedge clk) begin
        if (reset || start || rise) begin
            wdog <= '0;
        end else if (state == CMD || state == DATA) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYC-1
    assign wd_expire = (state == CMD || state == DATA) && !rise &&
                       (wdog == WD_W'(TIMEOUT_CYC - 2));
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (wd_expire) begin
                    state_nxt = IDLE;
                end else if (last_cmd_bit) begin
                    state_nxt = cmd_ok ? DATA : IDLE;
                end
            end
            DATA: begin
                if (wd_expire) begin
                    state_nxt = IDLE;
                end else if (last_data_bit) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        id_valid_d   = (state == REPORT);
        id_match_d   = (state == REPORT) && (data_sr == EXP_ID);
        opcode_err_d = last_cmd_bit && !cmd_ok;
        timeout_d    = wd_expire;
        busy_d       = (state_nxt != IDLE) || id_valid_d || opcode_err_d || timeout_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spiclk_q <= 1'b0;
            bit_cnt  <= 5'd0;
            cmd_sr   <= 8'd0;
            data_sr  <= 24'd0;
        end else begin
            spiclk_q <= SPICLK;
            if (start) begin
                bit_cnt <= 5'd0;
                cmd_sr  <= 8'd0;
                data_sr <= 24'd0;
            end else if (state == CMD && rise) begin
                cmd_sr  <= cmd_nxt;
                bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end else if (state == DATA && rise) begin
                data_sr <= {data_sr[22:0], SPIMISO};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            id_valid   <= 1'b0;
            id_data    <= 24'd0;
            id_match   <= 1'b0;
            opcode_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            busy       <= busy_d;
            id_valid   <= id_valid_d;
            id_match   <= id_match_d;
            opcode_err <= opcode_err_d;
            timeout    <= timeout_d;
            if (id_valid_d) begin
                id_data <= data_sr;
            end
        end
    end

endmodule

// File: tb/tb_rdid_capture.sv
// Directed bench for rdid_capture: SPI transactions driven at clk/4 with hand-computed results.
`define CHK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
        end \
    end

module tb_rdid_capture;

    logic        clk;
    logic        reset;
    logic        get_rdid;
    logic        SPICLK;
    logic        SPIMOSI;
    logic        SPIMISO;
    logic        busy;
    logic        id_valid;
    logic [23:0] id_data;
    logic        id_match;
    logic        opcode_err;
    logic        timeout;

    int total  = 0;
    int bad    = 0;
    int nvalid = 0;
    int nerr   = 0;
    int ntmo   = 0;

    rdid_capture #(
        .OPCODE      (8'h9F),
        .EXP_ID      (24'h202015),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .get_rdid   (get_rdid),
        .SPICLK     (SPICLK),
        .SPIMOSI    (SPIMOSI),
        .SPIMISO    (SPIMISO),
        .busy       (busy),
        .id_valid   (id_valid),
        .id_data    (id_data),
        .id_match   (id_match),
        .opcode_err (opcode_err),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (id_valid)   nvalid++;
        if (opcode_err) nerr++;
        if (timeout)    ntmo++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start();
        get_rdid = 1'b1;
        tick(1);
        get_rdid = 1'b0;
    endtask

    // Mode 0: data changes while SPICLK is low, each phase lasts 2 clk cycles
    task automatic send_bits(input logic [31:0] mo, input logic [31:0] mi, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            SPICLK  = 1'b0;
            SPIMOSI = mo[i];
            SPIMISO = mi[i];
            tick(2);
            SPICLK = 1'b1;
            tick(2);
        end
    endtask

    initial begin
        logic [31:0] mo_ok;
        logic [31:0] mo_bad;
        logic [31:0] mi_good;
        logic [31:0] mi_alt;

        mo_ok   = {8'h9F, 24'h000000};
        mo_bad  = {8'h9E, 24'h000000};
        mi_good = {8'h00, 24'h202015};
        mi_alt  = {8'h00, 24'hC22015};

        reset    = 1'b1;
        get_rdid = 1'b0;
        SPICLK   = 1'b0;
        SPIMOSI  = 1'b0;
        SPIMISO  = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(1);
        `CHK("rst_busy",       busy,       1'b0)
        `CHK("rst_id_valid",   id_valid,   1'b0)
        `CHK("rst_id_data",    id_data,    24'h000000)
        `CHK("rst_id_match",   id_match,   1'b0)
        `CHK("rst_opcode_err", opcode_err, 1'b0)
        `CHK("rst_timeout",    timeout,    1'b0)

        // Good transaction with an ignored strobe in the middle of the ID
        start();
        `CHK("t1_busy_rise", busy, 1'b1)
        send_bits(mo_ok, mi_good, 31, 16);
        get_rdid = 1'b1;
        tick(1);
        get_rdid = 1'b0;
        send_bits(mo_ok, mi_good, 15, 0);
        `CHK("t1_id_valid", id_valid, 1'b1)
        `CHK("t1_id_data",  id_data,  24'h202015)
        `CHK("t1_id_match", id_match, 1'b1)
        `CHK("t1_busy_hi",  busy,     1'b1)
        tick(1);
        `CHK("t1_valid_end", id_valid, 1'b0)
        `CHK("t1_busy_end",  busy,     1'b0)
        `CHK("t1_match_end", id_match, 1'b0)
        `CHK("t1_nvalid",    nvalid,   1)
        `CHK("t1_nerr",      nerr,     0)

        // Wrong opcode 0x9E: mismatch only in the bit sampled on the 8th rise
        SPICLK = 1'b0;
        tick(2);
        start();
        send_bits(mo_bad, mi_good, 31, 25);
        SPICLK  = 1'b0;
        SPIMOSI = 1'b0;
        tick(2);
        SPICLK = 1'b1;
        tick(1);
        `CHK("t2_opcode_err", opcode_err, 1'b1)
        `CHK("t2_busy_hi",    busy,       1'b1)
        tick(1);
        `CHK("t2_err_end",    opcode_err, 1'b0)
        `CHK("t2_busy_end",   busy,       1'b0)
        send_bits(mo_bad, mi_good, 23, 0);
        `CHK("t2_nvalid",     nvalid,     1)
        `CHK("t2_nerr",       nerr,       1)
        `CHK("t2_busy_idle",  busy,       1'b0)

        // Strobe coincides with a rise; that rise must not be counted
        SPICLK  = 1'b0;
        SPIMOSI = 1'b0;
        tick(2);
        SPICLK   = 1'b1;
        get_rdid = 1'b1;
        tick(1);
        get_rdid = 1'b0;
        `CHK("t3_busy_rise", busy, 1'b1)
        tick(1);
        send_bits(mo_ok, mi_alt, 31, 0);
        `CHK("t3_id_valid", id_valid, 1'b1)
        `CHK("t3_id_data",  id_data,  24'hC22015)
        `CHK("t3_id_match", id_match, 1'b0)
        tick(1);
        `CHK("t3_busy_end", busy,     1'b0)
        `CHK("t3_nerr",     nerr,     1)

        // SPICLK stalls after 12 rises
        SPICLK = 1'b0;
        tick(2);
        start();
        send_bits(mo_ok, mi_good, 31, 20);
`ifdef RDID_CAPTURE_TIMEOUT_EN
        tick(13);
        `CHK("t4_tmo_early",  timeout, 1'b0)
        tick(1);
        `CHK("t4_tmo_pulse",  timeout, 1'b1)
        `CHK("t4_busy_hi",    busy,    1'b1)
        tick(1);
        `CHK("t4_tmo_end",    timeout, 1'b0)
        `CHK("t4_busy_end",   busy,    1'b0)
        `CHK("t4_id_data",    id_data, 24'hC22015)
        `CHK("t4_ntmo",       ntmo,    1)
`else
        tick(40);
        `CHK("t4_no_timeout", timeout, 1'b0)
        `CHK("t4_stuck_busy", busy,    1'b1)
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        `CHK("t4_busy_reset", busy,    1'b0)
        `CHK("t4_ntmo",       ntmo,    0)
`endif
        `CHK("t4_nvalid", nvalid, 2)

        // Ignored second strobe, then reset at bit 20, then a clean capture
        SPICLK = 1'b0;
        tick(2);
        start();
        send_bits(mo_ok, mi_good, 31, 20);
        get_rdid = 1'b1;
        tick(1);
        get_rdid = 1'b0;
        send_bits(mo_ok, mi_good, 19, 12);
        `CHK("t5_busy_mid", busy, 1'b1)
        `CHK("t5_nerr_mid", nerr, 1)
        reset = 1'b1;
        tick(1);
        `CHK("t5_busy_in_reset", busy,     1'b0)
        `CHK("t5_valid_in_reset", id_valid, 1'b0)
        tick(1);
        reset  = 1'b0;
        SPICLK = 1'b0;
        tick(2);
        `CHK("t5_busy_after",  busy,    1'b0)
        `CHK("t5_id_data_rst", id_data, 24'h000000)
        `CHK("t5_nvalid_rst",  nvalid,  2)
        start();
        send_bits(mo_ok, mi_good, 31, 0);
        `CHK("t5_id_valid", id_valid, 1'b1)
        `CHK("t5_id_data",  id_data,  24'h202015)
        `CHK("t5_id_match", id_match, 1'b1)
        tick(1);
        `CHK("t5_busy_end", busy,     1'b0)
        `CHK("t5_nvalid",   nvalid,   3)
        `CHK("t5_nerr",     nerr,     1)

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rdid_capture.md
# rdid_capture

Passive SPI bus monitor that sits downstream of `spi_master` on the shared SPICLK/SPIMOSI/SPIMISO nets. It is started by the same `get_rdid` strobe that launches the master and verifies the 8-bit opcode the master shifts out. It then deserializes the 24-bit JEDEC ID returned by the M25P16 and reports it with a match flag against the expected part ID. It drives no bus signals and is the consumer of the RDID transaction's result.

## Interface
- `OPCODE`, 8'h9F, command byte expected on SPIMOSI
- `EXP_ID`, 24'h202015, expected JEDEC ID (manufacturer, type, capacity) for M25P16
- `TIMEOUT_CYC`, 1024, max clk cycles between SPICLK rising edges before abort (≥2)
- `clk` in 1, system clock
- `reset` in 1, synchronous, active-high
- `get_rdid` in 1, one-cycle start strobe, shared with spi_master
- `SPICLK` in 1, SPI clock, mode 0, generated from clk by spi_master
- `SPIMOSI` in 1, master-to-flash data
- `SPIMISO` in 1, flash-to-master data
- `busy` out 1, high from accepted start until return to IDLE
- `id_valid` out 1, one-cycle pulse, ID capture complete
- `id_data` out 24, captured ID, first received bit at [23]
- `id_match` out 1, `id_data == EXP_ID`, qualified by id_valid
- `opcode_err` out 1, one-cycle pulse, opcode mismatch
- `timeout` out 1, one-cycle pulse, watchdog abort

## Operation
- SPICLK rising edge: `rise = SPICLK & ~spiclk_q`, where `spiclk_q` is SPICLK registered on clk.
- SPIMOSI and SPIMISO are sampled in the cycle `rise` is high.
- States:
  - IDLE: `get_rdid` moves to CMD and clears the bit counter, shift registers and watchdog.
  - CMD: shift SPIMOSI MSB-first. On the 8th rise, compare the shift contents (including the bit sampled that cycle) to OPCODE.
    - Equal: go to DATA.
    - Different: pulse `opcode_err` the next cycle and go to IDLE.
  - DATA: shift SPIMISO MSB-first into a 24-bit register. On the 24th rise, go to REPORT.
  - REPORT: one cycle. Load `id_data`, pulse `id_valid`, drive `id_match`, return to IDLE.
- Bit counter is 5 bits. It resets to 0 on CMD→DATA; no wrap occurs.
- `id_data` holds its value until the next REPORT. It is not cleared at start.
- `id_match` is only meaningful while `id_valid` is high; it is 0 otherwise.
- `get_rdid` while busy is ignored and does not restart.
- A `rise` in IDLE, including in the same cycle as `get_rdid`, is not counted.
- Watchdog: counts clk cycles in CMD/DATA and resets on each `rise`. Reaching TIMEOUT_CYC−1 pulses `timeout` and returns to IDLE; partial data is discarded and `id_data` is unchanged.
- `reset` in any state forces IDLE on the next edge; no pulse outputs fire.

## Timing
- Reset values: busy=0, id_valid=0, id_data=24'h0, id_match=0, opcode_err=0, timeout=0, state=IDLE.
- Input constraint: each SPICLK high and low phase lasts ≥2 clk cycles (SPICLK ≤ clk/4). spi_master complies.
- `busy` rises the cycle after `get_rdid`.
- `id_valid` asserts 2 cycles after the clk edge on which the 32nd SPICLK rise is sampled (1 for the edge register, 1 for REPORT).
- `busy` falls the same cycle `id_valid` deasserts.
- `opcode_err` asserts the cycle after the 8th rise is registered.
- All outputs are registered.

## Configuration
- `RDID_CAPTURE_TIMEOUT_EN`
  - Defined: watchdog and `timeout` output are present as described.
  - Undefined: no watchdog counter, `timeout` is tied 0, and a stalled transaction remains in CMD/DATA until `reset`.

## Test plan
- Reset held 5 cycles, then released → all outputs at reset values, busy=0.
- get_rdid, master sends 0x9F, flash model returns 20 20 15 → one id_valid pulse, id_data=24'h202015, id_match=1, opcode_err=0.
- get_rdid, bus driven with MOSI=0x9E → opcode_err pulses once after the 8th rise, busy drops, id_valid never asserts.
- Valid opcode, MISO returns 24'hC22015 → id_valid with id_data=24'hC22015, id_match=0.
- With RDID_CAPTURE_TIMEOUT_EN and TIMEOUT_CYC=16, stop SPICLK after 12 rises → timeout pulses 15 cycles after the last rise, id_data unchanged.
- Second get_rdid mid-transfer, then reset asserted at bit 20 → second strobe ignored; after reset busy=0, no id_valid, and a following clean transaction captures 24'h202015.
